// File: rtl/debugger_stimulus_sequencer.sv
// Stimulus sequencer and latency checker for the hwdbg debugger: resets the debugger, drives a
// pattern on its input pins, raises the PL signal and times the PS interrupt against a timeout.
module debugger_stimulus_sequencer #(
  parameter int NUM_PINS   = 32,
  parameter int TIMEOUT_W  = 16,
  parameter int LAT_W      = 32,
  parameter int RESET_HOLD = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic [1:0]           io_mode,
  input  logic [NUM_PINS-1:0]  io_pattern,
  input  logic [TIMEOUT_W-1:0] io_timeout,
  input  logic [NUM_PINS-1:0]  io_outputPin,
  input  logic                 io_psOutInterrupt,
  output logic                 io_dutReset,
  output logic                 io_dutEn,
  output logic [NUM_PINS-1:0]  io_inputPin,
  output logic                 io_plInSignal,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_pass,
  output logic                 io_timedOut,
  output logic [LAT_W-1:0]     io_latency,
  output logic [NUM_PINS-1:0]  io_capturedOutput
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam int CMP_W = ((LAT_W > TIMEOUT_W) ? LAT_W : TIMEOUT_W) + 1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic [2:0] {IDLE, RESET_DUT, SETTLE, WAIT_IRQ, DONE} stateT;

  stateT                state, nextState;
  logic [HOLD_W-1:0]    holdCnt, holdCntD;
  logic [LAT_W-1:0]     waitCnt, waitCntD;
  logic [1:0]           modeReg, modeD;
  logic [NUM_PINS-1:0]  seedReg, seedD;
  logic [TIMEOUT_W-1:0] timeoutReg, timeoutD;
  logic                 dutResetD, dutEnD, plInSignalD, busyD, doneD, passD, timedOutD;
  logic [NUM_PINS-1:0]  inputPinD, capturedD;
  logic [LAT_W-1:0]     latencyD;
  logic                 accept, irqHit, tmoHit;

  // The current pattern lives in io_inputPin itself; this computes the value for the next WAIT cycle.
  function automatic logic [NUM_PINS-1:0] advance(input logic [1:0] mode,
                                                  input logic [NUM_PINS-1:0] p);
    case (mode)
      2'd1:    advance = (p << 1) | (p >> (NUM_PINS - 1));
      2'd2:    advance = p + NUM_PINS'(1);
      2'd3:    advance = ~p;
      default: advance = p;
    endcase
  endfunction

  assign accept = (state == IDLE) && io_start;
  assign irqHit = (state == WAIT_IRQ) && io_psOutInterrupt;
  // Timeout fires at the end of WAIT cycle T-1; the interrupt check takes priority over it.
  assign tmoHit = (state == WAIT_IRQ) && (timeoutReg != '0) &&
                  (CMP_W'(waitCnt) + CMP_W'(1) == CMP_W'(timeoutReg));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      holdCnt           <= '0;
      waitCnt           <= '0;
      modeReg           <= '0;
      seedReg           <= '0;
      timeoutReg        <= '0;
      io_dutReset       <= 1'b1;
      io_dutEn          <= 1'b0;
      io_inputPin       <= '0;
      io_plInSignal     <= 1'b0;
      io_busy           <= 1'b0;
      io_done           <= 1'b0;
      io_pass           <= 1'b0;
      io_timedOut       <= 1'b0;
      io_latency        <= '0;
      io_capturedOutput <= '0;
    end else begin
      state             <= nextState;
      holdCnt           <= holdCntD;
      waitCnt           <= waitCntD;
      modeReg           <= modeD;
      seedReg           <= seedD;
      timeoutReg        <= timeoutD;
      io_dutReset       <= dutResetD;
      io_dutEn          <= dutEnD;
      io_inputPin       <= inputPinD;
      io_plInSignal     <= plInSignalD;
      io_busy           <= busyD;
      io_done           <= doneD;
      io_pass           <= passD;
      io_timedOut       <= timedOutD;
      io_latency        <= latencyD;
      io_capturedOutput <= capturedD;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (io_start) nextState = RESET_DUT;
      RESET_DUT: if (holdCnt == HOLD_LAST) nextState = SETTLE;
      SETTLE:    nextState = WAIT_IRQ;
      WAIT_IRQ:  if (irqHit || tmoHit) nextState = DONE;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Outputs are registered: their next values are derived from the state being entered.
  always_comb begin
    holdCntD    = (state == RESET_DUT) ? holdCnt + HOLD_W'(1) : '0;
    waitCntD    = waitCnt;
    modeD       = modeReg;
    seedD       = seedReg;
    timeoutD    = timeoutReg;
    dutResetD   = io_dutReset;
    dutEnD      = io_dutEn;
    plInSignalD = io_plInSignal;
    inputPinD   = '0;
    busyD       = 1'b0;
    doneD       = 1'b0;
    passD       = io_pass;
    timedOutD   = io_timedOut;
    latencyD    = io_latency;
    capturedD   = io_capturedOutput;

    if (accept) begin
      modeD     = io_mode;
      seedD     = io_pattern;
      timeoutD  = io_timeout;
      passD     = 1'b0;
      timedOutD = 1'b0;
      latencyD  = '0;
      capturedD = '0;
    end

    if (irqHit) begin
      passD     = 1'b1;
      latencyD  = waitCnt;
      capturedD = io_outputPin;
    end else if (tmoHit) begin
      timedOutD = 1'b1;
      latencyD  = LAT_W'(timeoutReg);
    end

    case (nextState)
      RESET_DUT: begin
        busyD = 1'b1; dutResetD = 1'b1; dutEnD = 1'b1; plInSignalD = 1'b0;
      end
      SETTLE: begin
        busyD = 1'b1; dutResetD = 1'b0; dutEnD = 1'b1; plInSignalD = 1'b0;
      end
      WAIT_IRQ: begin
        busyD = 1'b1; dutResetD = 1'b0; dutEnD = 1'b1; plInSignalD = 1'b1;
        if (state == SETTLE) begin
          inputPinD = seedReg;
          waitCntD  = '0;
        end else begin
          inputPinD = advance(modeReg, io_inputPin);
          waitCntD  = (waitCnt == LAT_MAX) ? waitCnt : waitCnt + LAT_W'(1);
        end
      end
      DONE: begin
        doneD = 1'b1; dutResetD = 1'b0; dutEnD = 1'b1; plInSignalD = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debugger_stimulus_sequencer.sv
// Directed bench for debugger_stimulus_sequencer: hand-computed patterns, latencies and status
// for each mode, early/busy/reset corner cases, checked with immediate assertions.
module tb_debugger_stimulus_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic [1:0]  io_mode;
  logic [31:0] io_pattern;
  logic [15:0] io_timeout;
  logic [31:0] io_outputPin;
  logic        io_psOutInterrupt;
  logic        io_dutReset, io_dutEn, io_plInSignal, io_busy, io_done, io_pass, io_timedOut;
  logic [31:0] io_inputPin, io_latency, io_capturedOutput;

  int total = 0;
  int bad   = 0;
  int hi;

  debugger_stimulus_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .io_start          (io_start),
    .io_mode           (io_mode),
    .io_pattern        (io_pattern),
    .io_timeout        (io_timeout),
    .io_outputPin      (io_outputPin),
    .io_psOutInterrupt (io_psOutInterrupt),
    .io_dutReset       (io_dutReset),
    .io_dutEn          (io_dutEn),
    .io_inputPin       (io_inputPin),
    .io_plInSignal     (io_plInSignal),
    .io_busy           (io_busy),
    .io_done           (io_done),
    .io_pass           (io_pass),
    .io_timedOut       (io_timedOut),
    .io_latency        (io_latency),
    .io_capturedOutput (io_capturedOutput)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Presents a start for one edge; returns at the sample point of RESET_DUT cycle 0.
  task automatic startRun(input logic [1:0] mode, input logic [31:0] pattern, input logic [15:0] tmo);
    io_mode    = mode;
    io_pattern = pattern;
    io_timeout = tmo;
    io_start   = 1'b1;
    tick();
    io_start   = 1'b0;
  endtask

  // Counts cycles with io_dutReset high (optionally pulsing the interrupt in one of them),
  // checks SETTLE, and returns at the sample point of WAIT cycle 0.
  task automatic runToWait(input int irqAt, output int hiCycles);
    hiCycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (io_dutReset !== 1'b1) break;
      hiCycles++;
      io_psOutInterrupt = (i == irqAt);
      tick();
    end
    io_psOutInterrupt = 1'b0;
    check("settle_busy", io_busy, 1);
    check("settle_plIn", io_plInSignal, 0);
    tick();
    check("wait0_plIn", io_plInSignal, 1);
  endtask

  initial begin
    reset = 1'b0; io_start = 1'b0; io_mode = 2'd0; io_pattern = '0; io_timeout = '0;
    io_outputPin = '0; io_psOutInterrupt = 1'b0;
    tick(); tick();
    check("rst_dutReset", io_dutReset, 1);
    check("rst_dutEn", io_dutEn, 0);
    check("rst_busy", io_busy, 0);
    check("rst_done", io_done, 0);
    check("rst_inputPin", io_inputPin, 0);
    check("rst_plIn", io_plInSignal, 0);
    check("rst_pass", io_pass, 0);
    check("rst_latency", io_latency, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", io_busy, 0);

    // Mode 0: constant all-ones, interrupt in WAIT cycle 5.
    startRun(2'd0, 32'hFFFF_FFFF, 16'd100);
    check("m0_busy", io_busy, 1);
    check("m0_dutEn", io_dutEn, 1);
    check("m0_inputPin_rst", io_inputPin, 0);
    runToWait(-1, hi);
    check("m0_dutReset_cycles", hi, 10);
    for (int k = 0; k < 5; k++) begin
      check("m0_inputPin", io_inputPin, 32'hFFFF_FFFF);
      check("m0_done_low", io_done, 0);
      tick();
    end
    io_psOutInterrupt = 1'b1;
    io_outputPin      = 32'h1234_5678;
    tick();
    io_psOutInterrupt = 1'b0;
    io_outputPin      = '0;
    check("m0_done", io_done, 1);
    check("m0_done_busy", io_busy, 0);
    check("m0_done_plIn", io_plInSignal, 0);
    check("m0_done_inputPin", io_inputPin, 0);
    check("m0_done_dutReset", io_dutReset, 0);
    check("m0_done_dutEn", io_dutEn, 1);
    check("m0_pass", io_pass, 1);
    check("m0_timedOut", io_timedOut, 0);
    check("m0_latency", io_latency, 5);
    check("m0_captured", io_capturedOutput, 32'h1234_5678);
    tick();
    check("m0_done_pulse_end", io_done, 0);
    check("m0_pass_held", io_pass, 1);
    check("m0_latency_held", io_latency, 5);
    check("m0_captured_held", io_capturedOutput, 32'h1234_5678);

    // Mode 1: rotate-left, timeout 3, no interrupt.
    startRun(2'd1, 32'h8000_0001, 16'd3);
    check("m1_pass_cleared", io_pass, 0);
    check("m1_latency_cleared", io_latency, 0);
    check("m1_captured_cleared", io_capturedOutput, 0);
    runToWait(-1, hi);
    check("m1_pin0", io_inputPin, 32'h8000_0001);
    tick();
    check("m1_pin1", io_inputPin, 32'h0000_0003);
    tick();
    check("m1_pin2", io_inputPin, 32'h0000_0006);
    tick();
    check("m1_done", io_done, 1);
    check("m1_timedOut", io_timedOut, 1);
    check("m1_latency", io_latency, 3);
    check("m1_pass", io_pass, 0);
    tick();

    // Mode 2: increment with wrap, interrupt in cycle T-1 beats the timeout.
    startRun(2'd2, 32'hFFFF_FFFE, 16'd4);
    check("m2_timedOut_cleared", io_timedOut, 0);
    runToWait(-1, hi);
    check("m2_pin0", io_inputPin, 32'hFFFF_FFFE);
    tick();
    check("m2_pin1", io_inputPin, 32'hFFFF_FFFF);
    tick();
    check("m2_pin2", io_inputPin, 32'h0000_0000);
    tick();
    check("m2_pin3", io_inputPin, 32'h0000_0001);
    io_psOutInterrupt = 1'b1;
    io_outputPin      = 32'hCAFE_0003;
    tick();
    io_psOutInterrupt = 1'b0;
    check("m2_done", io_done, 1);
    check("m2_pass", io_pass, 1);
    check("m2_timedOut", io_timedOut, 0);
    check("m2_latency", io_latency, 3);
    check("m2_captured", io_capturedOutput, 32'hCAFE_0003);
    tick();

    // Mode 3: toggle, interrupt during RESET_DUT is ignored, timeout 2.
    startRun(2'd3, 32'hA5A5_A5A5, 16'd2);
    runToWait(3, hi);
    check("m3_dutReset_cycles", hi, 10);
    check("m3_busy_after_early_irq", io_busy, 1);
    check("m3_pin0", io_inputPin, 32'hA5A5_A5A5);
    tick();
    check("m3_pin1", io_inputPin, 32'h5A5A_5A5A);
    tick();
    check("m3_done", io_done, 1);
    check("m3_timedOut", io_timedOut, 1);
    check("m3_pass", io_pass, 0);
    check("m3_latency", io_latency, 2);
    tick();

    // Start while busy is ignored; the next start after done runs from a cleared status.
    startRun(2'd0, 32'h0000_000F, 16'd2);
    tick(); tick();
    io_mode = 2'd3; io_pattern = 32'h0000_DEAD; io_timeout = 16'd9; io_start = 1'b1;
    tick();
    io_start = 1'b0;
    runToWait(-1, hi);
    check("busy_start_pin0", io_inputPin, 32'h0000_000F);
    tick();
    check("busy_start_pin1", io_inputPin, 32'h0000_000F);
    tick();
    check("busy_start_done", io_done, 1);
    check("busy_start_latency", io_latency, 2);
    tick();
    check("no_queue_busy0", io_busy, 0);
    tick();
    check("no_queue_busy1", io_busy, 0);
    startRun(2'd0, 32'h0000_0033, 16'd0);
    check("second_timedOut_cleared", io_timedOut, 0);
    check("second_latency_cleared", io_latency, 0);
    runToWait(-1, hi);
    check("second_pin0", io_inputPin, 32'h0000_0033);
    io_psOutInterrupt = 1'b1;
    io_outputPin      = 32'h0000_0077;
    tick();
    io_psOutInterrupt = 1'b0;
    check("second_pass", io_pass, 1);
    check("second_latency", io_latency, 0);
    check("second_captured", io_capturedOutput, 32'h0000_0077);
    tick();

    // Reset asserted for one cycle mid-WAIT, then a normal run.
    startRun(2'd2, 32'h0000_0010, 16'd0);
    runToWait(-1, hi);
    tick(); tick(); tick();
    check("midrst_pin_before", io_inputPin, 32'h0000_0013);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_dutReset", io_dutReset, 1);
    check("midrst_busy", io_busy, 0);
    check("midrst_plIn", io_plInSignal, 0);
    check("midrst_inputPin", io_inputPin, 0);
    check("midrst_latency", io_latency, 0);
    check("midrst_dutEn", io_dutEn, 0);
    tick();
    check("midrst_idle_busy", io_busy, 0);
    startRun(2'd0, 32'h0000_0055, 16'd1);
    runToWait(-1, hi);
    check("postrst_dutReset_cycles", hi, 10);
    check("postrst_pin0", io_inputPin, 32'h0000_0055);
    tick();
    check("postrst_done", io_done, 1);
    check("postrst_timedOut", io_timedOut, 1);
    check("postrst_latency", io_latency, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debugger_stimulus_sequencer.md
Name: debugger_stimulus_sequencer

Overview:
Synthesizable, parametrised stimulus and checker for the hwdbg debugger top. It resets the debugger and drives its input pins with a programmable pattern mode. It asserts the PL input signal, then measures the latency until the PS interrupt fires, with a timeout. It replaces the fixed-stimulus plain simulation harness for on-fabric self-test and regression, and supports any pin count.

Parameters:
NUM_PINS, 32, width of the debugger input/output pin buses.
TIMEOUT_W, 16, width of the timeout value.
LAT_W, 32, width of the latency counter.
RESET_HOLD, 10, clocks the debugger reset is held during a run (minimum 1).

Ports:
clock  in  1  single clock for all logic.
reset  in  1  synchronous, active-low reset.
io_start  in  1  run request; sampled in IDLE only.
io_mode  in  2  pattern mode: 0 constant, 1 walking rotate-left, 2 increment, 3 toggle.
io_pattern  in  NUM_PINS  seed pattern, latched on accepted start.
io_timeout  in  TIMEOUT_W  max wait cycles, latched on start; 0 = wait forever.
io_outputPin  in  NUM_PINS  debugger output pins.
io_psOutInterrupt  in  1  debugger interrupt to PS.
io_dutReset  out  1  active-high reset to debugger.
io_dutEn  out  1  debugger enable.
io_inputPin  out  NUM_PINS  debugger input pins.
io_plInSignal  out  1  PL input signal to debugger.
io_busy  out  1  run in progress.
io_done  out  1  one-cycle pulse at run end.
io_pass  out  1  interrupt observed in last run.
io_timedOut  out  1  last run hit timeout.
io_latency  out  LAT_W  WAIT cycles before interrupt, or timeout value.
io_capturedOutput  out  NUM_PINS  io_outputPin sampled on interrupt cycle.

Behaviour:
- All outputs are registered.
- Reset value (reset low at a clock edge) applies to every output and to internal state, including mid-run:
  - io_dutReset=1.
  - All other outputs 0.
  - State IDLE.
- IDLE:
  - io_busy=0.
  - io_start=1 latches mode, pattern and timeout, then goes to RESET_DUT.
  - Clears pass, timedOut, latency and capturedOutput.
  - Leaves io_dutReset, io_dutEn and io_plInSignal as they were.
- RESET_DUT:
  - io_busy=1, io_dutReset=1, io_dutEn=1, io_inputPin=0, io_plInSignal=0.
  - Lasts exactly RESET_HOLD cycles.
- SETTLE:
  - 1 cycle, io_dutReset=0.
- WAIT:
  - io_plInSignal=1. io_inputPin shows the current pattern; it equals the seed in WAIT cycle 0.
  - The cycle counter k starts at 0 and increments by 1 per WAIT cycle.
- Pattern update after each WAIT cycle, by mode:
  - Mode 0: unchanged.
  - Mode 1: rotate left by 1; MSB wraps to bit 0.
  - Mode 2: +1 modulo 2^NUM_PINS; all-ones wraps to 0.
  - Mode 3: bitwise invert.
- WAIT exit on interrupt:
  - Trigger: io_psOutInterrupt sampled 1 in WAIT cycle k.
  - Sets latency=k, pass=1, capturedOutput=io_outputPin (same-cycle sample), then goes to DONE.
- WAIT exit on timeout:
  - Trigger: timeout T≠0 and no interrupt in cycles 0..T-1.
  - Sets latency=T, timedOut=1, then goes to DONE.
- Simultaneous events: an interrupt in cycle T-1 wins, giving pass=1 and latency=T-1.
- Latency counter saturates at 2^LAT_W-1 (relevant when T=0); it does not wrap.
- Interrupt sampled in IDLE, RESET_DUT or SETTLE is ignored.
- io_start while busy is ignored; no queuing.
- DONE:
  - 1 cycle with io_done=1, io_busy=0, io_plInSignal=0, io_inputPin=0.
  - io_dutReset=0 and io_dutEn=1 remain held.
  - Then returns to IDLE.
- pass, timedOut, latency and capturedOutput hold until the next accepted start or reset. pass and timedOut are never both 1.
- Start-to-first-WAIT latency is RESET_HOLD+1 cycles after the accepting edge.

Test Plan:
- Reset low mid-WAIT, for 1 cycle -> next edge: io_dutReset=1; io_busy, io_plInSignal, io_inputPin, io_latency all 0; state IDLE; a subsequent start runs normally.
- Mode 0, pattern 0xFFFF_FFFF, timeout 100, interrupt raised in WAIT cycle 5 with io_outputPin=0x1234_5678 -> pass=1, timedOut=0, latency=5, capturedOutput=0x1234_5678, io_done pulse of exactly 1 cycle; io_dutReset high exactly 10 cycles.
- Mode 1, pattern 0x8000_0001, no interrupt, timeout 3 -> io_inputPin sequence 0x8000_0001, 0x0000_0003, 0x0000_0006; timedOut=1, latency=3, pass=0.
- Mode 2, pattern 0xFFFF_FFFE, timeout 4, interrupt in cycle 3 (equal to T-1) -> inputs 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001; pass=1, latency=3, timedOut=0.
- Mode 3, pattern 0xA5A5_A5A5, interrupt pulsed during RESET_DUT, then none, timeout 2 -> the early interrupt is ignored; inputs 0xA5A5_A5A5, 0x5A5A_5A5A; timedOut=1, latency=2.
- io_start pulsed again while busy, then after io_done -> the busy start is ignored; the second run begins from IDLE with status cleared.
